// File: rtl/spi_pixel_assembler_if.sv
// Bus bundle for spi_pixel_assembler: SPI beat input, pixel FIFO head and frame status.
// addr_out is present only when SPI_PIXEL_ADDR_EN is defined.
interface spi_pixel_assembler_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int LINES       = 1,
   parameter int PIXEL_WIDTH = 16,
   parameter int H_PIXELS    = 320,
   parameter int V_PIXELS    = 240
);
   localparam int HW = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int VW = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
`ifdef SPI_PIXEL_ADDR_EN
   localparam int AW = (H_PIXELS * V_PIXELS > 1) ? $clog2(H_PIXELS * V_PIXELS) : 1;
`endif

   logic [DATA_WIDTH-1:0]  data_in [LINES];
   logic                   data_valid_in;
   logic                   chip_sel_in;
   logic [PIXEL_WIDTH-1:0] pixel_out;
   logic [HW-1:0]          hcount_out;
   logic [VW-1:0]          vcount_out;
`ifdef SPI_PIXEL_ADDR_EN
   logic [AW-1:0]          addr_out;
`endif
   logic                   pixel_valid_out;
   logic                   pixel_ready_in;
   logic                   frame_done_out;
   logic                   frame_err_out;
   logic                   overflow_out;

   modport slave (
      input  data_in, data_valid_in, chip_sel_in, pixel_ready_in,
      output pixel_out, hcount_out, vcount_out,
`ifdef SPI_PIXEL_ADDR_EN
      output addr_out,
`endif
      output pixel_valid_out, frame_done_out, frame_err_out, overflow_out
   );

   modport master (
      output data_in, data_valid_in, chip_sel_in, pixel_ready_in,
      input  pixel_out, hcount_out, vcount_out,
`ifdef SPI_PIXEL_ADDR_EN
      input  addr_out,
`endif
      input  pixel_valid_out, frame_done_out, frame_err_out, overflow_out
   );
endinterface

// File: rtl/spi_pixel_assembler.sv
// Packs SPI beats into raster-tagged pixels, checks frame length against CS and buffers
// them in a show-ahead FIFO that reports overflow. SPI_PIXEL_ADDR_EN adds a linear address.
module spi_pixel_assembler #(
   parameter int DATA_WIDTH  = 8,
   parameter int LINES       = 1,
   parameter int PIXEL_WIDTH = 16,
   parameter int H_PIXELS    = 320,
   parameter int V_PIXELS    = 240,
   parameter int FIFO_DEPTH  = 4
) (
   input logic                  clk_in,
   input logic                  rst_n_in,
   spi_pixel_assembler_if.slave bus
);
   localparam int BEAT_W = DATA_WIDTH * LINES;
   localparam int BEATS  = PIXEL_WIDTH / BEAT_W;
   localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int HW     = (H_PIXELS > 1) ? $clog2(H_PIXELS) : 1;
   localparam int VW     = (V_PIXELS > 1) ? $clog2(V_PIXELS) : 1;
   localparam int FW     = $clog2(FIFO_DEPTH);
`ifdef SPI_PIXEL_ADDR_EN
   localparam int AW     = (H_PIXELS * V_PIXELS > 1) ? $clog2(H_PIXELS * V_PIXELS) : 1;
`endif

   typedef enum logic [1:0] {IDLE, ACTIVE, CLOSE} state_e;

   typedef struct packed {
      logic [PIXEL_WIDTH-1:0] pix;
      logic [HW-1:0]          h;
      logic [VW-1:0]          v;
`ifdef SPI_PIXEL_ADDR_EN
      logic [AW-1:0]          a;
`endif
   } entry_t;

   state_e                 state_q, state_d;
   logic [BW-1:0]          beat_cnt_q, beat_cnt_d;
   logic [PIXEL_WIDTH-1:0] shift_q, shift_d;
   logic [HW-1:0]          h_q, h_d;
   logic [VW-1:0]          v_q, v_d;
`ifdef SPI_PIXEL_ADDR_EN
   logic [AW-1:0]          addr_q, addr_d;
`endif
   logic                   end_q, end_d, long_q, long_d;
   logic                   done_q, done_d, err_q, err_d, ovf_q, ovf_d;
   entry_t                 mem_q [FIFO_DEPTH];
   entry_t                 mem_d [FIFO_DEPTH];
   logic [FW:0]            wr_q, wr_d, rd_q, rd_d;

   logic [BEAT_W-1:0]      beat;
   logic [PIXEL_WIDTH-1:0] pix_next;
   logic                   accept, last_beat, complete, push, pop, full, empty;
   entry_t                 wr_entry;

   // Lane 0 lands in the most significant slot of the beat word.
   always_comb begin
      beat = '0;
      for (int unsigned i = 0; i < LINES; i++)
         beat[(LINES-1-i)*DATA_WIDTH +: DATA_WIDTH] = bus.data_in[i];
   end

   always_comb begin
      accept    = (state_q == ACTIVE) && bus.data_valid_in;
      last_beat = (beat_cnt_q == BW'(BEATS - 1));
      complete  = accept && last_beat;
      pix_next  = (shift_q << BEAT_W) | PIXEL_WIDTH'(beat);
      empty     = (wr_q == rd_q);
      full      = (wr_q[FW] != rd_q[FW]) && (wr_q[FW-1:0] == rd_q[FW-1:0]);
      pop       = !empty && bus.pixel_ready_in;
      push      = complete && !end_q;
      wr_entry.pix = pix_next;
      wr_entry.h   = h_q;
      wr_entry.v   = v_q;
`ifdef SPI_PIXEL_ADDR_EN
      wr_entry.a   = addr_q;
`endif
   end

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      shift_d    = shift_q;
      h_d        = h_q;
      v_d        = v_q;
`ifdef SPI_PIXEL_ADDR_EN
      addr_d     = addr_q;
`endif
      end_d      = end_q;
      long_d     = long_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.chip_sel_in) begin
               state_d    = ACTIVE;
               beat_cnt_d = '0;
               h_d        = '0;
               v_d        = '0;
`ifdef SPI_PIXEL_ADDR_EN
               addr_d     = '0;
`endif
               end_d      = 1'b0;
               long_d     = 1'b0;
            end
         end
         ACTIVE: begin
            if (accept) begin
               shift_d    = pix_next;
               beat_cnt_d = last_beat ? '0 : beat_cnt_q + BW'(1);
            end
            // end_q marks that the last raster position has been filled; coordinates then hold.
            if (complete) begin
               if (end_q) begin
                  long_d = 1'b1;
               end else if (h_q == HW'(H_PIXELS - 1) && v_q == VW'(V_PIXELS - 1)) begin
                  end_d = 1'b1;
               end else begin
                  if (h_q == HW'(H_PIXELS - 1)) begin
                     h_d = '0;
                     v_d = v_q + VW'(1);
                  end else begin
                     h_d = h_q + HW'(1);
                  end
`ifdef SPI_PIXEL_ADDR_EN
                  addr_d = addr_q + AW'(1);
`endif
               end
            end
            if (bus.chip_sel_in) begin
               state_d = CLOSE;
               done_d  = end_d && !long_d && (beat_cnt_d == '0);
               err_d   = !done_d;
            end
         end
         CLOSE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      if (push && (!full || pop)) begin
         mem_d[wr_q[FW-1:0]] = wr_entry;
         wr_d = wr_q + (FW+1)'(1);
      end
      if (pop)
         rd_d = rd_q + (FW+1)'(1);
      ovf_d = ovf_q || (push && full && !pop);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q    <= IDLE;
         beat_cnt_q <= '0;
         shift_q    <= '0;
         h_q        <= '0;
         v_q        <= '0;
`ifdef SPI_PIXEL_ADDR_EN
         addr_q     <= '0;
`endif
         end_q      <= 1'b0;
         long_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++)
            mem_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         shift_q    <= shift_d;
         h_q        <= h_d;
         v_q        <= v_d;
`ifdef SPI_PIXEL_ADDR_EN
         addr_q     <= addr_d;
`endif
         end_q      <= end_d;
         long_q     <= long_d;
         done_q     <= done_d;
         err_q      <= err_d;
         ovf_q      <= ovf_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         mem_q      <= mem_d;
      end
   end

   assign bus.pixel_out       = mem_q[rd_q[FW-1:0]].pix;
   assign bus.hcount_out      = mem_q[rd_q[FW-1:0]].h;
   assign bus.vcount_out      = mem_q[rd_q[FW-1:0]].v;
`ifdef SPI_PIXEL_ADDR_EN
   assign bus.addr_out        = mem_q[rd_q[FW-1:0]].a;
`endif
   assign bus.pixel_valid_out = !empty;
   assign bus.frame_done_out  = done_q;
   assign bus.frame_err_out   = err_q;
   assign bus.overflow_out    = ovf_q;
endmodule

// File: tb/tb_spi_pixel_assembler.sv
// Bench for spi_pixel_assembler: table-driven frames, random frames against a raster
// model, plus overflow, two-lane and mid-frame reset sequences.
module tb_spi_pixel_assembler;
   localparam int H     = 4;
   localparam int V     = 2;
   localparam int DEPTH = 4;

   typedef struct { logic [15:0] pix; int h; int v; int a; } ent_t;
   typedef struct { int nbeats; int exp_pix; bit exp_done; bit exp_err; } vec_t;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   int         n_checks = 0;
   int         n_pass   = 0;
   int         done_cnt = 0;
   int         err_cnt  = 0;
   ent_t       got_q[$];
   ent_t       exp_q[$];
   logic [7:0] beats[$];
   bit         exp_done;
   vec_t       vecs[6];

   always #5 clk = ~clk;

   spi_pixel_assembler_if #(.DATA_WIDTH(8), .LINES(1), .PIXEL_WIDTH(16),
                            .H_PIXELS(H), .V_PIXELS(V)) ia ();
   spi_pixel_assembler_if #(.DATA_WIDTH(8), .LINES(2), .PIXEL_WIDTH(16),
                            .H_PIXELS(H), .V_PIXELS(V)) ib ();

   spi_pixel_assembler #(.DATA_WIDTH(8), .LINES(1), .PIXEL_WIDTH(16), .H_PIXELS(H),
                         .V_PIXELS(V), .FIFO_DEPTH(DEPTH))
      dut_a (.clk_in(clk), .rst_n_in(rst_n), .bus(ia));
   spi_pixel_assembler #(.DATA_WIDTH(8), .LINES(2), .PIXEL_WIDTH(16), .H_PIXELS(H),
                         .V_PIXELS(V), .FIFO_DEPTH(DEPTH))
      dut_b (.clk_in(clk), .rst_n_in(rst_n), .bus(ib));

   always @(negedge clk) begin : monitor
      ent_t e;
      if (ia.pixel_valid_out && ia.pixel_ready_in) begin
         e.pix = ia.pixel_out;
         e.h   = int'(ia.hcount_out);
         e.v   = int'(ia.vcount_out);
`ifdef SPI_PIXEL_ADDR_EN
         e.a   = int'(ia.addr_out);
`else
         e.a   = 0;
`endif
         got_q.push_back(e);
      end
      if (ia.frame_done_out) done_cnt++;
      if (ia.frame_err_out)  err_cnt++;
   end

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Raster model: pixel i is beats 2i,2i+1 at (i%H, i/H); only the first H*V are kept.
   task automatic model();
      exp_q.delete();
      for (int i = 0; i < beats.size() / 2; i++) begin
         ent_t e;
         if (i < H * V) begin
            e.pix = {beats[2*i], beats[2*i+1]};
            e.h   = i % H;
            e.v   = i / H;
            e.a   = i;
            exp_q.push_back(e);
         end
      end
      exp_done = (beats.size() == 2 * H * V);
   endtask

   task automatic run_frame_a(input int gap_max);
      got_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      ia.chip_sel_in = 1'b0;
      tick();
      foreach (beats[i]) begin
         ia.data_in[0]     = beats[i];
         ia.data_valid_in  = 1'b1;
         tick();
         ia.data_valid_in  = 1'b0;
         if (gap_max > 0) tick($urandom_range(gap_max, 0));
      end
      ia.chip_sel_in = 1'b1;
      tick(8);
   endtask

   task automatic compare_frame(input string tag);
      check($sformatf("%s npix", tag), got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         check($sformatf("%s pix[%0d]", tag, i), int'(got_q[i].pix), int'(exp_q[i].pix));
         check($sformatf("%s h[%0d]", tag, i), got_q[i].h, exp_q[i].h);
         check($sformatf("%s v[%0d]", tag, i), got_q[i].v, exp_q[i].v);
`ifdef SPI_PIXEL_ADDR_EN
         check($sformatf("%s addr[%0d]", tag, i), got_q[i].a, exp_q[i].a);
`endif
      end
      check($sformatf("%s done", tag), done_cnt, int'(exp_done));
      check($sformatf("%s err", tag), err_cnt, int'(!exp_done));
   endtask

   task automatic check_a_zero(input string tag);
      check($sformatf("%s pixel", tag), int'(ia.pixel_out), 0);
      check($sformatf("%s hcount", tag), int'(ia.hcount_out), 0);
      check($sformatf("%s vcount", tag), int'(ia.vcount_out), 0);
`ifdef SPI_PIXEL_ADDR_EN
      check($sformatf("%s addr", tag), int'(ia.addr_out), 0);
`endif
      check($sformatf("%s valid", tag), int'(ia.pixel_valid_out), 0);
      check($sformatf("%s done", tag), int'(ia.frame_done_out), 0);
      check($sformatf("%s err", tag), int'(ia.frame_err_out), 0);
      check($sformatf("%s overflow", tag), int'(ia.overflow_out), 0);
   endtask

   initial begin
      vecs[0] = '{16, 8, 1'b1, 1'b0};
      vecs[1] = '{15, 7, 1'b0, 1'b1};
      vecs[2] = '{18, 8, 1'b0, 1'b1};
      vecs[3] = '{0,  0, 1'b0, 1'b1};
      vecs[4] = '{17, 8, 1'b0, 1'b1};
      vecs[5] = '{2,  1, 1'b0, 1'b1};

      ia.data_in[0] = '0; ia.data_valid_in = 1'b0; ia.chip_sel_in = 1'b1; ia.pixel_ready_in = 1'b0;
      ib.data_in[0] = '0; ib.data_in[1] = '0;
      ib.data_valid_in = 1'b0; ib.chip_sel_in = 1'b1; ib.pixel_ready_in = 1'b0;
      tick(2);
      check_a_zero("reset");
      rst_n = 1'b1;
      tick(2);
      ia.pixel_ready_in = 1'b1;

      foreach (vecs[k]) begin
         beats.delete();
         for (int i = 0; i < vecs[k].nbeats; i++) beats.push_back(8'(i));
         run_frame_a(0);
         model();
         compare_frame($sformatf("vec%0d", k));
         check($sformatf("vec%0d tbl npix", k), got_q.size(), vecs[k].exp_pix);
         check($sformatf("vec%0d tbl done", k), done_cnt, int'(vecs[k].exp_done));
         check($sformatf("vec%0d tbl err", k), err_cnt, int'(vecs[k].exp_err));
      end

      for (int k = 0; k < 20; k++) begin
         int n;
         n = (k % 4 == 0) ? 16 : int'($urandom_range(20, 0));
         beats.delete();
         for (int i = 0; i < n; i++) beats.push_back(8'($urandom));
         run_frame_a(2);
         model();
         compare_frame($sformatf("rnd%0d", k));
      end

      // Overflow: five pixels into a four-entry FIFO with no consumer.
      ia.pixel_ready_in = 1'b0;
      beats.delete();
      for (int i = 0; i < 10; i++) beats.push_back(8'(i));
      run_frame_a(0);
      check("ovf popped", got_q.size(), 0);
      check("ovf err", err_cnt, 1);
      check("ovf flag", int'(ia.overflow_out), 1);
      check("ovf valid", int'(ia.pixel_valid_out), 1);
      check("ovf head pix", int'(ia.pixel_out), 16'h0001);
      ia.pixel_ready_in = 1'b1;
      tick(6);
      check("ovf drained", got_q.size(), 4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         check($sformatf("ovf pix[%0d]", i), int'(got_q[i].pix), i * 16'h0202 + 1);
         check($sformatf("ovf h[%0d]", i), got_q[i].h, i);
         check($sformatf("ovf v[%0d]", i), got_q[i].v, 0);
      end
      check("ovf sticky", int'(ia.overflow_out), 1);
      beats.delete();
      for (int i = 0; i < 16; i++) beats.push_back(8'(16 + i));
      run_frame_a(0);
      model();
      compare_frame("post_ovf");
      check("post_ovf sticky", int'(ia.overflow_out), 1);

      // Two lanes: one beat per pixel, lane 0 in the high byte.
      ib.chip_sel_in = 1'b0;
      tick();
      ib.data_in[0] = 8'hAB; ib.data_in[1] = 8'hCD; ib.data_valid_in = 1'b1;
      check("lanes valid pre", int'(ib.pixel_valid_out), 0);
      tick();
      ib.data_in[0] = 8'h12; ib.data_in[1] = 8'h34;
      check("lanes valid", int'(ib.pixel_valid_out), 1);
      check("lanes pix", int'(ib.pixel_out), 16'hABCD);
      check("lanes h", int'(ib.hcount_out), 0);
      tick();
      ib.data_valid_in = 1'b0;
      check("lanes head held", int'(ib.pixel_out), 16'hABCD);
      ib.pixel_ready_in = 1'b1;
      tick();
      check("lanes pix2", int'(ib.pixel_out), 16'h1234);
      check("lanes h2", int'(ib.hcount_out), 1);
      ib.pixel_ready_in = 1'b0;

      // Asynchronous reset three beats into a frame.
      ia.pixel_ready_in = 1'b0;
      got_q.delete();
      done_cnt = 0;
      err_cnt  = 0;
      ia.chip_sel_in = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         ia.data_in[0] = 8'(8'h40 + i); ia.data_valid_in = 1'b1;
         tick();
      end
      ia.data_valid_in = 1'b0;
      check("rst pre valid", int'(ia.pixel_valid_out), 1);
      #2 rst_n = 1'b0;
      #1;
      check_a_zero("midrst");
      check("midrst b valid", int'(ib.pixel_valid_out), 0);
      ia.chip_sel_in = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      check("midrst no done", done_cnt, 0);
      check("midrst no err", err_cnt, 0);
      ia.pixel_ready_in = 1'b1;
      beats.delete();
      for (int i = 0; i < 16; i++) beats.push_back(8'(i));
      run_frame_a(0);
      model();
      compare_frame("after_rst");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
